// File: rtl/range_meas_pkg.sv
// Shared definitions for the range measurement block.
// Holds the FSM state encoding and the default values of every
// parameter, so the top level and the tick generator agree on them.
package range_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TRIG_CYCLES = 10;
  localparam int DEF_PRESCALE    = 1;
  localparam int DEF_TIMEOUT     = 1000;
  localparam int DEF_HOLDOFF     = 20;

endpackage

// File: rtl/range_tick.sv
// Prescaler / tick generator.
// Emits a one-cycle tick every PRESCALE clock cycles while run is high.
// The phase is frozen while run is low and forced back to zero by clear,
// so the first tick after a clear lands PRESCALE cycles later.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-high reset
//   run   - advance the prescaler
//   clear - restart the phase at zero
//   tick  - high for one cycle at the end of each PRESCALE period
module range_tick
  import range_meas_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = run && (phase == LAST);

  // Phase counter wraps at PRESCALE-1; the tick fires on the wrap cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (run) begin
      if (phase == LAST) begin
        phase <= '0;
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end

endmodule

// File: rtl/range_meas.sv
// Ultrasonic-style range measurement controller.
// Issues a trigger pulse, waits for the sensor echo, measures the echo
// width in prescaled ticks and reports it (all ones on timeout), then
// holds off before allowing the next trigger. Continuous mode re-triggers
// automatically after each hold-off while enabled.
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous active-high reset
//   start      - rising edge requests one measurement
//   enable     - allows new triggers (never aborts a running one)
//   cont       - re-trigger automatically after each hold-off
//   s_echo     - asynchronous echo input from the sensor
//   s_trigger  - trigger pulse to the sensor
//   meas       - last echo width in ticks, all ones on timeout
//   meas_valid - one-cycle strobe when meas/timeout are updated
//   timeout    - last result was a timeout
//   busy       - high in every state except idle
module range_meas
  import range_meas_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TRIG_CYCLES = DEF_TRIG_CYCLES,
  parameter int PRESCALE    = DEF_PRESCALE,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int HOLDOFF     = DEF_HOLDOFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic             cont,
  input  logic             s_echo,
  output logic             s_trigger,
  output logic [CNT_W-1:0] meas,
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);

  localparam int CYC_MAX = (TRIG_CYCLES > HOLDOFF) ? TRIG_CYCLES : HOLDOFF;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  state_t           state, state_next;
  logic             echo_m, echo_s;
  logic             start_q, start_edge;
  logic [CYC_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] to_cnt, echo_cnt;
  logic             tick, prescale_run, prescale_clear;
  logic             timeout_hit, capture_echo, capture_timeout;

  assign start_edge   = start && !start_q;
  assign prescale_run = (state == ST_WAIT_RISE) || (state == ST_MEASURE);
  assign timeout_hit  = tick && (to_cnt == CNT_W'(TIMEOUT - 1));
  assign busy         = (state != ST_IDLE);

  range_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .run  (prescale_run),
    .clear(prescale_clear),
    .tick (tick)
  );

  // Echo synchronizer and the registered copy of start for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_m  <= 1'b0;
      echo_s  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      echo_m  <= s_echo;
      echo_s  <= echo_m;
      start_q <= start;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. In MEASURE the echo fall is checked before the
  // timeout so a fall on the timeout tick still reports the count.
  always_comb begin
    state_next      = state;
    prescale_clear  = 1'b0;
    capture_echo    = 1'b0;
    capture_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_edge && enable) begin
          state_next = ST_TRIG;
        end
      end
      ST_TRIG: begin
        if (cyc_cnt == CYC_W'(TRIG_CYCLES - 1)) begin
          state_next     = ST_WAIT_RISE;
          prescale_clear = 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        if (timeout_hit) begin
          capture_timeout = 1'b1;
          state_next      = ST_HOLD;
        end else if (echo_s) begin
          state_next = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (!echo_s) begin
          capture_echo = 1'b1;
          state_next   = ST_HOLD;
        end else if (timeout_hit) begin
          capture_timeout = 1'b1;
          state_next      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cyc_cnt == CYC_W'(HOLDOFF - 1)) begin
          state_next = (cont && enable) ? ST_TRIG : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Cycle counter timing the trigger pulse and the hold-off; restarts on
  // every state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_cnt <= '0;
    end else if (state_next != state) begin
      cyc_cnt <= '0;
    end else if ((state == ST_TRIG) || (state == ST_HOLD)) begin
      cyc_cnt <= cyc_cnt + CYC_W'(1);
    end
  end

  // Timeout and echo counters. The echo count also takes the tick of the
  // rise cycle in WAIT_RISE, so the result covers the full echo width.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt   <= '0;
      echo_cnt <= '0;
    end else if (prescale_clear) begin
      to_cnt   <= '0;
      echo_cnt <= '0;
    end else if (prescale_run && tick) begin
      to_cnt <= to_cnt + CNT_W'(1);
      if (echo_s && (echo_cnt != {CNT_W{1'b1}})) begin
        echo_cnt <= echo_cnt + CNT_W'(1);
      end
    end
  end

  // Registered outputs; the trigger follows the next state so it is
  // aligned with TRIG and drops at once on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_trigger  <= 1'b0;
      meas       <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      s_trigger  <= (state_next == ST_TRIG);
      meas_valid <= capture_echo || capture_timeout;
      if (capture_echo) begin
        meas    <= echo_cnt;
        timeout <= 1'b0;
      end else if (capture_timeout) begin
        meas    <= {CNT_W{1'b1}};
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_range_meas.sv
// Self-checking bench for range_meas: a default instance for the
// main behaviour and a PRESCALE=4 instance for the tick scaling.
module tb_range_meas;

  typedef struct {
    int          delay;
    int          width;
    logic [15:0] expMeas;
    logic        expTimeout;
    int          expLatency;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset, start, enable, cont, s_echo, start4, s_echo4;
  logic        s_trigger, meas_valid, timeout, busy;
  logic [15:0] meas;
  logic        s_trigger4, meas_valid4, timeout4, busy4;
  logic [15:0] meas4;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mvCount = 0;
  int   mvCycle = 0;
  int   trigRises = 0;
  int   trigRiseCycle = 0;
  int   trigFallCycle = 0;
  int   trigLen = 0;
  int   lastTrigLen = 0;
  logic prevTrig = 1'b0;

  vec_t vecs[8];

  always #5 clock = ~clock;

  range_meas dut (
    .clock(clock), .reset(reset), .start(start), .enable(enable),
    .cont(cont), .s_echo(s_echo), .s_trigger(s_trigger), .meas(meas),
    .meas_valid(meas_valid), .timeout(timeout), .busy(busy)
  );

  range_meas #(.PRESCALE(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .enable(enable),
    .cont(1'b0), .s_echo(s_echo4), .s_trigger(s_trigger4), .meas(meas4),
    .meas_valid(meas_valid4), .timeout(timeout4), .busy(busy4)
  );

  // Output monitor, sampled just after each rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (meas_valid) begin
        mvCount++;
        mvCycle = cyc;
      end
      if (s_trigger && !prevTrig) begin
        trigRises++;
        trigRiseCycle = cyc;
        trigLen = 0;
      end
      if (s_trigger) trigLen++;
      if (!s_trigger && prevTrig) begin
        trigFallCycle = cyc;
        lastTrigLen = trigLen;
      end
      prevTrig = s_trigger;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitTrigFall(output bit ok);
    for (int i = 0; i < 60 && !s_trigger; i++) @(negedge clock);
    for (int i = 0; i < 60 && s_trigger; i++) @(negedge clock);
    ok = !s_trigger && (trigRises > 0);
  endtask

  task automatic driveEcho(input int delay, input int width);
    repeat (delay) @(negedge clock);
    if (width > 0) begin
      s_echo = 1'b1;
      repeat (width) @(negedge clock);
      s_echo = 1'b0;
    end
  endtask

  task automatic waitMeasValid(input int base, input int budget, output bit ok);
    for (int i = 0; i < budget && mvCount == base; i++) @(negedge clock);
    ok = (mvCount != base);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clock);
    checkOutput("idle_after_hold", busy, 0);
  endtask

  task automatic applyStimulus(input vec_t v, output bit ok, output int mvBase);
    bit seen;
    pulseStart();
    waitTrigFall(seen);
    checkOutput("trigger_seen", seen, 1);
    mvBase = mvCount;
    driveEcho(v.delay, v.width);
    waitMeasValid(mvBase, 1200, ok);
  endtask

  initial begin
    bit ok;
    int mvBase, trigBase, rb;

    vecs[0] = '{250, 500, 16'd500,   1'b0, 753};
    vecs[1] = '{0,   1,   16'd1,     1'b0, 4};
    vecs[2] = '{10,  3,   16'd3,     1'b0, 16};
    vecs[3] = '{100, 100, 16'd100,   1'b0, 203};
    vecs[4] = '{20,  0,   16'hFFFF,  1'b1, 1000};
    vecs[5] = '{250, 747, 16'd747,   1'b0, 1000};
    vecs[6] = '{250, 748, 16'hFFFF,  1'b1, 1000};
    vecs[7] = '{900, 200, 16'hFFFF,  1'b1, 1000};

    reset = 1'b1; start = 1'b0; enable = 1'b1; cont = 1'b0;
    s_echo = 1'b0; start4 = 1'b0; s_echo4 = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_trigger", s_trigger, 0);
    checkOutput("rst_meas", meas, 0);
    checkOutput("rst_meas_valid", meas_valid, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_busy4", busy4, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Enable low blocks a start request.
    enable = 1'b0;
    trigBase = trigRises;
    pulseStart();
    repeat (30) @(negedge clock);
    checkOutput("disabled_no_trigger", trigRises - trigBase, 0);
    checkOutput("disabled_not_busy", busy, 0);
    enable = 1'b1;

    $display("[TB] single-shot vectors");
    for (int k = 0; k < 8; k++) begin
      trigBase = trigRises;
      applyStimulus(vecs[k], ok, mvBase);
      checkOutput($sformatf("v%0d_mv_seen", k), ok, 1);
      checkOutput($sformatf("v%0d_meas", k), meas, vecs[k].expMeas);
      checkOutput($sformatf("v%0d_timeout", k), timeout, vecs[k].expTimeout);
      checkOutput($sformatf("v%0d_latency", k), mvCycle - trigFallCycle, vecs[k].expLatency);
      checkOutput($sformatf("v%0d_trig_len", k), lastTrigLen, 10);
      for (int i = 0; i < 300 && s_echo; i++) @(negedge clock);
      waitIdle();
      checkOutput($sformatf("v%0d_strobes", k), mvCount - mvBase, 1);
      checkOutput($sformatf("v%0d_trig_count", k), trigRises - trigBase, 1);
      repeat (3) @(negedge clock);
    end

    $display("[TB] continuous mode");
    cont = 1'b1;
    trigBase = trigRises;
    pulseStart();
    for (int r = 0; r < 3; r++) begin
      waitTrigFall(ok);
      checkOutput("cont_trig_seen", ok, 1);
      if (r == 2) enable = 1'b0;
      mvBase = mvCount;
      driveEcho(30, 100);
      waitMeasValid(mvBase, 200, ok);
      checkOutput("cont_mv_seen", ok, 1);
      checkOutput("cont_meas", meas, 100);
      checkOutput("cont_timeout", timeout, 0);
      if (r < 2) begin
        rb = trigRises;
        for (int i = 0; i < 60 && trigRises == rb; i++) @(negedge clock);
        checkOutput("cont_gap", trigRiseCycle - mvCycle, 20);
      end
    end
    repeat (60) @(negedge clock);
    checkOutput("cont_stop_triggers", trigRises - trigBase, 3);
    checkOutput("cont_stop_busy", busy, 0);
    cont = 1'b0;
    enable = 1'b1;

    $display("[TB] reset during measure");
    pulseStart();
    waitTrigFall(ok);
    checkOutput("rstm_trig_seen", ok, 1);
    repeat (10) @(negedge clock);
    s_echo = 1'b1;
    repeat (20) @(negedge clock);
    checkOutput("rstm_busy_before", busy, 1);
    mvBase = mvCount;
    reset = 1'b1;
    #1;
    checkOutput("rstm_trigger", s_trigger, 0);
    checkOutput("rstm_busy", busy, 0);
    checkOutput("rstm_meas", meas, 0);
    checkOutput("rstm_timeout", timeout, 0);
    checkOutput("rstm_meas_valid", meas_valid, 0);
    s_echo = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    checkOutput("rstm_no_strobe", mvCount - mvBase, 0);
    applyStimulus('{5, 37, 16'd37, 1'b0, 45}, ok, mvBase);
    checkOutput("rstm_after_mv_seen", ok, 1);
    checkOutput("rstm_after_meas", meas, 37);
    checkOutput("rstm_after_latency", mvCycle - trigFallCycle, 45);
    waitIdle();

    $display("[TB] start edges while busy");
    trigBase = trigRises;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    start = 1'b1;
    repeat (2) @(negedge clock);
    start = 1'b0;
    waitTrigFall(ok);
    checkOutput("busy_trig_seen", ok, 1);
    for (int k = 0; k < 5; k++) begin
      start = 1'b1;
      repeat (3) @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
    end
    mvBase = mvCount;
    driveEcho(5, 50);
    waitMeasValid(mvBase, 200, ok);
    checkOutput("busy_mv_seen", ok, 1);
    checkOutput("busy_meas", meas, 50);
    repeat (5) @(negedge clock);
    start = 1'b1;
    repeat (2) @(negedge clock);
    start = 1'b0;
    repeat (60) @(negedge clock);
    checkOutput("busy_trig_count", trigRises - trigBase, 1);
    checkOutput("busy_idle", busy, 0);

    $display("[TB] prescale 4");
    for (int k = 0; k < 2; k++) begin
      start4 = 1'b1;
      @(negedge clock);
      start4 = 1'b0;
      for (int i = 0; i < 60 && s_trigger4; i++) @(negedge clock);
      checkOutput("ps4_trig_fell", s_trigger4, 0);
      repeat (50) @(negedge clock);
      s_echo4 = 1'b1;
      repeat ((k == 0) ? 400 : 8) @(negedge clock);
      s_echo4 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
        @(negedge clock);
        if (meas_valid4) ok = 1'b1;
      end
      checkOutput("ps4_mv_seen", ok, 1);
      checkOutput("ps4_meas", meas4, (k == 0) ? 100 : 2);
      checkOutput("ps4_timeout", timeout4, 0);
      for (int i = 0; i < 100 && busy4; i++) @(negedge clock);
      checkOutput("ps4_idle", busy4, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/range_meas.md
RANGE_MEAS -- requirements
Module: range_meas

Interface
REQ-001 Parameter CNT_W, default 16: width of the echo count and of the timeout counter.
REQ-002 Parameter TRIG_CYCLES, default 10: s_trigger pulse length in clock cycles.
REQ-003 Parameter PRESCALE, default 1: clock cycles per count tick (>=1).
REQ-004 Parameter TIMEOUT, default 1000: ticks allowed from end of trigger to echo fall (< 2^CNT_W - 1).
REQ-005 Parameter HOLDOFF, default 20: idle clock cycles after each measurement before the next trigger.
REQ-006 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port start, input, 1: a rising edge requests one measurement.
REQ-009 Port enable, input, 1: high allows triggers to be issued.
REQ-010 Port cont, input, 1: high selects continuous re-trigger mode.
REQ-011 Port s_echo, input, 1: asynchronous echo pulse from the sensor.
REQ-012 Port s_trigger, output, 1: trigger pulse to the sensor.
REQ-013 Port meas, output, CNT_W: last echo width in ticks; all-ones on timeout.
REQ-014 Port meas_valid, output, 1: one-cycle strobe when meas is updated.
REQ-015 Port timeout, output, 1: high when the last result timed out; updated with meas_valid.
REQ-016 Port busy, output, 1: high in every state except IDLE.

Function
REQ-017 s_echo SHALL pass through a 2-flop synchronizer; the synchronized value is echo_s.
REQ-018 start SHALL be edge-detected against a registered copy; the edge is start_edge.
REQ-019 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE and HOLD.
REQ-020 IDLE: if start_edge and enable, go to TRIG on the next cycle; otherwise stay in IDLE.
REQ-021 TRIG: s_trigger SHALL be high for exactly TRIG_CYCLES cycles, then go to WAIT_RISE with the tick, timeout and echo counters cleared.
REQ-022 Ticks SHALL be generated by a prescaler that runs only in WAIT_RISE and MEASURE: one tick every PRESCALE clock cycles, and the prescaler phase clears on entry to WAIT_RISE.
REQ-023 The timeout counter SHALL increment on every tick in WAIT_RISE and MEASURE.
REQ-024 WAIT_RISE: when echo_s is 1, go to MEASURE.
REQ-025 MEASURE: the echo counter SHALL increment on every tick while echo_s is 1 and saturate at 2^CNT_W-1 with no wrap.
REQ-026 MEASURE: when echo_s is 0, set meas to the echo count, timeout to 0, pulse meas_valid, and go to HOLD.
REQ-027 Reaching TIMEOUT ticks in WAIT_RISE or MEASURE SHALL set meas to all ones, timeout to 1, pulse meas_valid, and go to HOLD.
REQ-028 If an echo fall and the timeout occur in the same cycle, the echo fall SHALL win.
REQ-029 HOLD SHALL last HOLDOFF cycles; it then goes to TRIG if cont and enable, otherwise to IDLE.
REQ-030 start_edge outside IDLE SHALL be ignored and not queued.
REQ-031 enable low SHALL NOT abort a measurement in progress; it only blocks new triggers.
REQ-032 meas and timeout SHALL hold their values between meas_valid strobes.

Reset
REQ-033 Reset SHALL force: state IDLE; all counters 0; s_trigger 0; meas 0; meas_valid 0; timeout 0; busy 0; synchronizer and edge registers 0.
REQ-034 Reset asserted mid-measurement SHALL abort it with no meas_valid strobe, and s_trigger SHALL drop immediately.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding and the default parameter constants.
REQ-036 The prescaler/tick generator SHALL be one sub-module, range_tick.

Verification (defaults, PRESCALE=1)
REQ-037 start edge, echo high 250 cycles after s_trigger falls and held high 500 cycles -> s_trigger high 10 cycles; meas=500, timeout=0, one meas_valid strobe.
REQ-038 start edge with echo never high -> meas=16'hFFFF, timeout=1, meas_valid strobe 1000 ticks after s_trigger falls.
REQ-039 cont=1, enable=1, one start edge, echo 100 cycles each round -> repeated measurements each reporting meas=100, with next s_trigger rise 20 cycles after each meas_valid; enable=0 -> stops after the current measurement.
REQ-040 PRESCALE=4, echo high 400 cycles -> meas=100.
REQ-041 reset asserted during MEASURE -> outputs at reset values immediately, no meas_valid strobe; a start edge after release works normally.
REQ-042 start edges during busy, and echo fall in the same cycle as timeout -> no extra trigger; the result reports the echo count with timeout=0.
